// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/control sequencer for an addi/bne datapath.
// Fetches over a req/valid handshake, decodes from IR and steers the PC using the datapath eq flag.
module control_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [DATA_WIDTH-1:0]    imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     imem_valid,
  input  logic                     eq,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     RegWrite,
  output logic                     ALUctrl,
  output logic                     ALUsrc,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     halted,
  output logic [DATA_WIDTH-1:0]    instret
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] ir;

  logic                         is_exec;
  logic                         is_addi;
  logic                         is_bne;
  logic                         is_zero;
  logic signed [DATA_WIDTH-1:0] imm_i;
  logic signed [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0]        pc_next;

  assign is_exec = (state == EXEC);
  assign is_addi = (ir[6:0] == OP_IMM)    && (ir[14:12] == 3'b000);
  assign is_bne  = (ir[6:0] == OP_BRANCH) && (ir[14:12] == 3'b001);
  assign is_zero = (ir == '0);

  assign imm_i = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
  assign imm_b = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  assign rs1 = ADDRESS_WIDTH'(ir[19:15]);
  assign rs2 = ADDRESS_WIDTH'(ir[24:20]);
  assign rd  = ADDRESS_WIDTH'(ir[11:7]);

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_comb begin
    RegWrite = 1'b0;
    ALUctrl  = 1'b0;
    ALUsrc   = 1'b0;
    ImmOp    = '0;
    if (is_exec) begin
      if (is_addi) begin
        ALUsrc   = 1'b1;
        ImmOp    = imm_i;
        // Writes to x0 are suppressed, and reset kills a pulse already in flight.
        RegWrite = (rd != '0) && !rst;
      end else if (is_bne) begin
        ALUctrl = 1'b1;
        ImmOp   = imm_b;
      end
    end
  end

  always_comb begin
    pc_next = pc + DATA_WIDTH'(4);
    if (is_bne && !eq)
      pc_next = pc + imm_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= DATA_WIDTH'(32'h0000_0013);
      instret <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          // The all-zero word halts without retiring or moving the PC.
          if (is_zero) begin
            state <= HALT;
          end else begin
            pc      <= pc_next;
            instret <= instret + DATA_WIDTH'(1);
            state   <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: one task per scenario, inline checks,
// inputs driven just after the falling edge and outputs sampled 1 time unit later.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        eq = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, ALUctrl, ALUsrc;
  logic [31:0] ImmOp, pc, instret;
  logic        halted;

  int errors = 0;
  int checks = 0;

  control_sequencer #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .eq(eq), .rs1(rs1), .rs2(rs2), .rd(rd),
    .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmOp(ImmOp),
    .pc(pc), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  // Present one instruction in the current FETCH cycle; returns sampling the EXEC cycle.
  task automatic fetch(input logic [31:0] instr);
    imem_valid = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = '0;
    #1;
  endtask

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite[%0d]: got %b want 0", i, RegWrite); end
    end
    rst = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h want 00000000", instret); end
    checks++; if (rd !== 5'd0 || ALUsrc !== 1'b0) begin errors++; $display("FAIL reset_ir: got rd=%0d alusrc=%b want 0/0", rd, ALUsrc); end
  endtask

  task automatic test_addi;
    fetch(32'h0FF00313);
    checks++; if (rd !== 5'd6 || rs1 !== 5'd0) begin errors++; $display("FAIL addi_regs: got rd=%0d rs1=%0d want 6/0", rd, rs1); end
    checks++; if (ALUsrc !== 1'b1 || ALUctrl !== 1'b0) begin errors++; $display("FAIL addi_alu: got src=%b ctrl=%b want 1/0", ALUsrc, ALUctrl); end
    checks++; if (ImmOp !== 32'd255) begin errors++; $display("FAIL addi_imm: got %h want 000000ff", ImmOp); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL addi_we: got %b want 1", RegWrite); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL addi_req_exec: got %b want 0", imem_req); end
    next_cycle();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL addi_we_pulse: got %b want 0", RegWrite); end
    checks++; if (pc !== 32'd4 || imem_addr !== 32'd4) begin errors++; $display("FAIL addi_pc: got pc=%h addr=%h want 4", pc, imem_addr); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL addi_instret: got %0d want 1", instret); end
    fetch(32'hFFF00313);
    checks++; if (ImmOp !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_negimm: got %h want ffffffff", ImmOp); end
    next_cycle();
    checks++; if (pc !== 32'd8 || instret !== 32'd2) begin errors++; $display("FAIL addi2_state: got pc=%h instret=%0d want 8/2", pc, instret); end
  endtask

  task automatic test_bne;
    fetch(32'hFE031EE3);
    eq = 1'b0;
    checks++; if (rs1 !== 5'd6 || rs2 !== 5'd0) begin errors++; $display("FAIL bne_regs: got rs1=%0d rs2=%0d want 6/0", rs1, rs2); end
    checks++; if (ALUctrl !== 1'b1 || ALUsrc !== 1'b0 || RegWrite !== 1'b0) begin errors++; $display("FAIL bne_ctrl: got ctrl=%b src=%b we=%b want 1/0/0", ALUctrl, ALUsrc, RegWrite); end
    checks++; if (ImmOp !== 32'hFFFFFFFC) begin errors++; $display("FAIL bne_imm: got %h want fffffffc", ImmOp); end
    next_cycle();
    checks++; if (pc !== 32'd4) begin errors++; $display("FAIL bne_taken_pc: got %h want 00000004", pc); end
    fetch(32'h00000073);
    next_cycle();
    checks++; if (pc !== 32'd8) begin errors++; $display("FAIL bne_nop_pc: got %h want 00000008", pc); end
    fetch(32'hFE031EE3);
    eq = 1'b1;
    #1;
    checks++; if (ALUctrl !== 1'b1 || ALUsrc !== 1'b0 || RegWrite !== 1'b0) begin errors++; $display("FAIL bne_eq_ctrl: got ctrl=%b src=%b we=%b want 1/0/0", ALUctrl, ALUsrc, RegWrite); end
    next_cycle();
    eq = 1'b0;
    checks++; if (pc !== 32'd12) begin errors++; $display("FAIL bne_fall_pc: got %h want 0000000c", pc); end
    checks++; if (instret !== 32'd5) begin errors++; $display("FAIL bne_instret: got %0d want 5", instret); end
  endtask

  task automatic test_wait_states;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin errors++; $display("FAIL wait_hold[%0d]: got req=%b addr=%h want 1/0000000c", i, imem_req, imem_addr); end
      if (i == 3) begin
        imem_valid = 1'b1;
        imem_rdata = 32'h00100093;
      end
      @(negedge clk); #1;
    end
    imem_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || rd !== 5'd1 || ImmOp !== 32'd1) begin errors++; $display("FAIL wait_exec: got we=%b rd=%0d imm=%h want 1/1/1", RegWrite, rd, ImmOp); end
    next_cycle();
    checks++; if (pc !== 32'd16 || instret !== 32'd6) begin errors++; $display("FAIL wait_done: got pc=%h instret=%0d want 10/6", pc, instret); end
  endtask

  task automatic test_halt_nop;
    fetch(32'h00000073);
    checks++; if (RegWrite !== 1'b0 || ALUsrc !== 1'b0 || ALUctrl !== 1'b0 || ImmOp !== 32'h0) begin errors++; $display("FAIL nop_ctrl: got we=%b src=%b ctrl=%b imm=%h want all 0", RegWrite, ALUsrc, ALUctrl, ImmOp); end
    next_cycle();
    checks++; if (pc !== 32'd20 || instret !== 32'd7) begin errors++; $display("FAIL nop_state: got pc=%h instret=%0d want 14/7", pc, instret); end
    fetch(32'h00000000);
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL halt_we: got %b want 0", RegWrite); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_flags[%0d]: got halted=%b req=%b want 1/0", i, halted, imem_req); end
      checks++; if (pc !== 32'd20 || instret !== 32'd7) begin errors++; $display("FAIL halt_frozen[%0d]: got pc=%h instret=%0d want 14/7", i, pc, instret); end
    end
    do_reset();
    checks++; if (pc !== 32'h0 || imem_req !== 1'b1 || halted !== 1'b0 || instret !== 32'h0) begin errors++; $display("FAIL halt_reset: got pc=%h req=%b halted=%b instret=%0d want 0/1/0/0", pc, imem_req, halted, instret); end
  endtask

  task automatic test_edges;
    fetch(32'h00500013);
    checks++; if (RegWrite !== 1'b0 || ALUsrc !== 1'b1 || ImmOp !== 32'd5) begin errors++; $display("FAIL addi_x0: got we=%b src=%b imm=%h want 0/1/5", RegWrite, ALUsrc, ImmOp); end
    next_cycle();
    checks++; if (pc !== 32'd4) begin errors++; $display("FAIL addi_x0_pc: got %h want 00000004", pc); end
    do_reset();
    fetch(32'hFE031EE3);
    eq = 1'b0;
    next_cycle();
    checks++; if (pc !== 32'hFFFFFFFC || imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL bne_wrap: got pc=%h addr=%h want fffffffc", pc, imem_addr); end
    do_reset();
    fetch(32'h0FF00313);
    rst = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_exec_we: got %b want 0", RegWrite); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || imem_req !== 1'b1 || instret !== 32'h0) begin errors++; $display("FAIL rst_exec_state: got pc=%h req=%b instret=%0d want 0/1/0", pc, imem_req, instret); end
    rst = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h0FF00313;
    @(negedge clk);
    rst = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    #1;
    checks++; if (imem_req !== 1'b1 || rd !== 5'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL rst_discard: got req=%b rd=%0d we=%b want 1/0/0", imem_req, rd, RegWrite); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bne();
    test_wait_states();
    test_halt_nop();
    test_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle fetch/decode/control block that drives the single-cycle datapath (register file + ALU + immediate mux). It fetches 32-bit instructions from instruction memory over a req/valid handshake and decodes the `addi`/`bne` subset. It then produces the datapath's register addresses, `RegWrite`, `ALUctrl`, `ALUsrc` and `ImmOp`, and closes the branch loop using the datapath's `eq` flag.

## Interface
- `DATA_WIDTH`, default 32: instruction, PC and immediate width.
- `ADDRESS_WIDTH`, default 5: register address width.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req` output 1: fetch request; held high until accepted.
- `imem_addr` output DATA_WIDTH: byte address of the instruction being fetched (equals `pc`).
- `imem_rdata` input DATA_WIDTH: instruction word; valid when `imem_valid` is high.
- `imem_valid` input 1: fetch response strobe.
- `eq` input 1: datapath ALU equality flag, high when ALUop1 == ALUop2.
- `rs1`, `rs2`, `rd` output ADDRESS_WIDTH: register addresses, taken from IR[19:15], IR[24:20] and IR[11:7].
- `RegWrite` output 1: register write enable; one-cycle pulse.
- `ALUctrl` output 1: 0 = add, 1 = subtract/compare.
- `ALUsrc` output 1: 0 = register operand 2, 1 = `ImmOp`.
- `ImmOp` output DATA_WIDTH: sign-extended immediate.
- `pc` output DATA_WIDTH: current program counter.
- `halted` output 1: high once the HALT state is reached.
- `instret` output DATA_WIDTH: retired-instruction counter.

## Operation
- State register with states FETCH, EXEC, HALT; instruction register IR.
- Reset values:
  - state = FETCH, `pc` = 0, IR = 0x00000013 (`addi x0,x0,0`), `instret` = 0.
  - `halted` = 0, `RegWrite` = 0, `imem_req` = 1 from the first post-reset cycle.
- FETCH:
  - Drive `imem_req` = 1 and `imem_addr` = `pc`.
  - On a cycle with `imem_valid` = 1, load IR with `imem_rdata` and go to EXEC; otherwise stay in FETCH.
  - `imem_valid` is ignored in EXEC and HALT.
- EXEC lasts one cycle. `imem_req` = 0. Controls are decoded combinationally from IR:
  - `addi` (opcode 0010011, funct3 000):
    - `ALUctrl` = 0, `ALUsrc` = 1, `ImmOp` = sext(IR[31:20]).
    - `RegWrite` = 1 only if `rd` != 0.
    - `pc` ← `pc` + 4.
  - `bne` (opcode 1100011, funct3 001):
    - `ALUctrl` = 1, `ALUsrc` = 0, `RegWrite` = 0.
    - `ImmOp` = sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}).
    - `pc` ← (`eq` ? `pc` + 4 : `pc` + `ImmOp`), with `eq` sampled at the end of EXEC.
  - All-zero instruction (0x00000000): no write; go to HALT; `pc` unchanged; `instret` not incremented.
  - Any other encoding is a NOP: `RegWrite` = 0, `ALUctrl` = 0, `ALUsrc` = 0, `ImmOp` = 0, `pc` ← `pc` + 4.
  - Every non-halt EXEC increments `instret` by 1. The next state is FETCH.
- HALT:
  - `halted` = 1, `imem_req` = 0, `RegWrite` = 0.
  - Remains in HALT until `rst`.
- Outside EXEC:
  - `RegWrite` = 0, `ALUctrl` = 0, `ALUsrc` = 0, `ImmOp` = 0.
  - `rs1`/`rs2`/`rd` still follow IR.
- Arithmetic:
  - PC and branch-target addition is modulo 2^DATA_WIDTH (wraps silently).
  - No alignment check; `pc[1:0]` is passed through as computed.
  - `instret` wraps from 0xFFFFFFFF to 0.

## Timing
- Minimum instruction time is 2 cycles: FETCH with `imem_valid` in the same cycle as `imem_req`, then EXEC.
- Each memory wait cycle adds one cycle in FETCH; `imem_addr` is stable throughout the wait.
- `RegWrite` is high for exactly the EXEC cycle. The regfile writes on the edge that ends EXEC, so the write is visible to the next instruction's EXEC.
- `pc` updates on the edge that ends EXEC; `imem_addr` reflects the new PC in the following FETCH cycle.
- Reset mid-operation, in any state (including FETCH with a response pending, EXEC, or HALT):
  - On the next edge all registers take their reset values.
  - A response arriving in the reset cycle is discarded.
  - `RegWrite` is forced to 0 during any cycle in which `rst` = 1.
- Memory contract: `imem_valid` is only asserted while `imem_req` = 1. A response accepted in FETCH consumes the request.

## Test plan
- Reset behaviour: hold `rst` 2 cycles, release, memory with zero wait → `pc` = 0, `imem_req` = 1, `imem_addr` = 0, `halted` = 0, `instret` = 0, `RegWrite` = 0 in every cycle while `rst` = 1.
- `addi`: feed 0x0FF00313 (`addi x6,x0,255`) at PC 0 → EXEC shows `rd` = 6, `rs1` = 0, `ALUsrc` = 1, `ALUctrl` = 0, `ImmOp` = 255, `RegWrite` = 1 for one cycle; `pc` = 4; `instret` = 1.
  - Then 0xFFF00313 → `ImmOp` = 0xFFFFFFFF.
- `bne`: feed 0xFE031EE3 (`bne x6,x0,-4`) at PC 8.
  - With `eq` = 0 → `pc` = 4.
  - With `eq` = 1 → `pc` = 12.
  - `ALUctrl` = 1, `ALUsrc` = 0, `RegWrite` = 0 in both cases.
- Wait states: delay `imem_valid` by 3 cycles → `imem_req` and `imem_addr` are held for 4 FETCH cycles; instruction completes in 5 cycles; `instret` increments once.
- Halt and NOP:
  - Feed 0x00000073 → NOP, `pc` += 4, `instret` += 1.
  - Then 0x00000000 → `halted` = 1 and `imem_req` = 0 forever; `pc` and `instret` are frozen.
  - Assert `rst` → FETCH at `pc` = 0.
- Edge cases:
  - `addi` with `rd` = 0 → `RegWrite` stays 0.
  - `bne` at `pc` = 0 with offset −4 and `eq` = 0 → `pc` = 0xFFFFFFFC.
  - `rst` asserted during EXEC of an `addi` → no `RegWrite` pulse in that cycle; `pc` = 0 on the next cycle.
